// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file write arbiter.
package regfile_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned ADDR_WIDTH = 2;
    localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
        return NUM_REGS'(1) << a;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester/read-port/RF-control bundle of the write arbiter.
interface regfile_write_arbiter_if;
    import regfile_pkg::*;

    logic                  wrValid0;
    logic                  wrValid1;
    logic                  wrReady0;
    logic                  wrReady1;
    logic [ADDR_WIDTH-1:0] wrAddr0;
    logic [ADDR_WIDTH-1:0] wrAddr1;
    logic [DATA_WIDTH-1:0] wrData0;
    logic [DATA_WIDTH-1:0] wrData1;
    logic                  rdReq;
    logic                  rdGrant;
    logic                  rfIsReading;
    logic [ADDR_WIDTH-1:0] rfSelWrite;
    logic [DATA_WIDTH-1:0] rfWriteIn;
    logic [NUM_REGS-1:0]   pendingMask;

    modport master (
        output wrValid0, wrValid1, wrAddr0, wrAddr1, wrData0, wrData1, rdReq,
        input  wrReady0, wrReady1, rdGrant, rfIsReading, rfSelWrite, rfWriteIn, pendingMask
    );

    modport slave (
        input  wrValid0, wrValid1, wrAddr0, wrAddr1, wrData0, wrData1, rdReq,
        output wrReady0, wrReady1, rdGrant, rfIsReading, rfSelWrite, rfWriteIn, pendingMask
    );

endinterface

// File: rtl/regfile_req_slot.sv
// One-entry holding slot for a write-back requester; ready is the inverse of the full flop.
module regfile_req_slot
    import regfile_pkg::*;
#(
    parameter bit ZERO_REG_RO = 1'b0
) (
    input  logic    clk,
    input  logic    resetN,
    input  logic    valid_i,
    input  wr_req_t req_i,
    input  logic    clear_i,
    output logic    ready_o,
    output logic    full_o,
    output logic    load_o,
    output wr_req_t slot_o
);

    logic    full_q, full_d;
    wr_req_t slot_q, slot_d;
    logic    accept, drop;

    assign accept = valid_i & ~full_q;
    // A dropped write still completes its handshake but never occupies the slot.
    assign drop   = ZERO_REG_RO && (req_i.addr == '0);
    assign load_o = accept & ~drop;

    always_comb begin
        full_d = full_q;
        slot_d = slot_q;
        if (load_o) begin
            full_d = 1'b1;
            slot_d = req_i;
        end else if (clear_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            full_q <= 1'b0;
            slot_q <= '0;
        end else begin
            full_q <= full_d;
            slot_q <= slot_d;
        end
    end

    assign ready_o = ~full_q;
    assign full_o  = full_q;
    assign slot_o  = slot_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the RF write port between two write-back slots and a read requester,
// with read priority bounded by a starvation limit.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned MAX_STALL   = 4,
    parameter bit          ZERO_REG_RO = 1'b0
) (
    input logic                   clk,
    input logic                   resetN,
    regfile_write_arbiter_if.slave bus
);

    localparam int unsigned StallW = $clog2(MAX_STALL + 1);

    wr_req_t req0, req1, slot0, slot1;
    logic    full0, full1, load0, load1, clr0, clr1, rdy0, rdy1;
    logic    pick1, same_reg;

    logic                  is_reading_q, is_reading_d;
    logic [ADDR_WIDTH-1:0] sel_q, sel_d;
    logic [DATA_WIDTH-1:0] write_in_q, write_in_d;
    logic                  rd_grant_q, rd_grant_d;
    logic [StallW-1:0]     stall_q, stall_d;
    logic                  last_q, last_d;
    logic                  older1_q, older1_d;

    assign req0 = '{addr: bus.wrAddr0, data: bus.wrData0};
    assign req1 = '{addr: bus.wrAddr1, data: bus.wrData1};

    regfile_req_slot #(.ZERO_REG_RO(ZERO_REG_RO)) u_slot0 (
        .clk    (clk),
        .resetN (resetN),
        .valid_i(bus.wrValid0),
        .req_i  (req0),
        .clear_i(clr0),
        .ready_o(rdy0),
        .full_o (full0),
        .load_o (load0),
        .slot_o (slot0)
    );

    regfile_req_slot #(.ZERO_REG_RO(ZERO_REG_RO)) u_slot1 (
        .clk    (clk),
        .resetN (resetN),
        .valid_i(bus.wrValid1),
        .req_i  (req1),
        .clear_i(clr1),
        .ready_o(rdy1),
        .full_o (full1),
        .load_o (load1),
        .slot_o (slot1)
    );

    // Both slots aimed at one register: the older must commit first to avoid WAW.
    assign same_reg = |(onehot(slot0.addr) & onehot(slot1.addr));

    always_comb begin
        is_reading_d = 1'b1;
        sel_d        = sel_q;
        write_in_d   = write_in_q;
        rd_grant_d   = 1'b0;
        stall_d      = stall_q;
        last_d       = last_q;
        clr0         = 1'b0;
        clr1         = 1'b0;
        pick1        = 1'b0;
        if (!full0 && !full1) begin
            rd_grant_d = bus.rdReq;
            stall_d    = '0;
        end else if (bus.rdReq && (stall_q < StallW'(MAX_STALL))) begin
            rd_grant_d = 1'b1;
            stall_d    = stall_q + StallW'(1);
        end else begin
            if (full0 && full1) begin
                pick1 = same_reg ? older1_q : ~last_q;
            end else begin
                pick1 = full1;
            end
            is_reading_d = 1'b0;
            sel_d        = pick1 ? slot1.addr : slot0.addr;
            write_in_d   = pick1 ? slot1.data : slot0.data;
            clr0         = ~pick1;
            clr1         = pick1;
            last_d       = pick1;
            stall_d      = '0;
        end
    end

    // Age tracking: a slot loaded while the other stays full is the younger one.
    always_comb begin
        older1_d = older1_q;
        if (load0 && full1 && !clr1) begin
            older1_d = 1'b1;
        end else if (load1 && full0 && !clr0) begin
            older1_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            is_reading_q <= 1'b1;
            sel_q        <= '0;
            write_in_q   <= '0;
            rd_grant_q   <= 1'b0;
            stall_q      <= '0;
            last_q       <= 1'b1;
            older1_q     <= 1'b0;
        end else begin
            is_reading_q <= is_reading_d;
            sel_q        <= sel_d;
            write_in_q   <= write_in_d;
            rd_grant_q   <= rd_grant_d;
            stall_q      <= stall_d;
            last_q       <= last_d;
            older1_q     <= older1_d;
        end
    end

    assign bus.wrReady0    = rdy0;
    assign bus.wrReady1    = rdy1;
    assign bus.rdGrant     = rd_grant_q;
    assign bus.rfIsReading = is_reading_q;
    assign bus.rfSelWrite  = sel_q;
    assign bus.rfWriteIn   = write_in_q;
    assign bus.pendingMask = (full0 ? onehot(slot0.addr) : '0)
                           | (full1 ? onehot(slot1.addr) : '0)
                           | (!is_reading_q ? onehot(sel_q) : '0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: per-cycle vector table plus sequences for reset, alternation and R0 drop.
module tb_regfile_write_arbiter;

    localparam logic [63:0] A = 64'hAFED_AFED_AFED_AFED;
    localparam logic [63:0] B = 64'h0777_0777_0777_0777;
    localparam logic [63:0] C = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] Z = 64'h0;

    logic clk;
    logic resetN;
    int   checks;
    int   errors;
    logic [63:0] rf [4];

    regfile_write_arbiter_if bus ();
    regfile_write_arbiter_if bus_z ();

    regfile_write_arbiter #(.MAX_STALL(4), .ZERO_REG_RO(1'b0)) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    regfile_write_arbiter #(.MAX_STALL(4), .ZERO_REG_RO(1'b1)) dut_z (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus_z)
    );

    always #5 clk = ~clk;

    // Downstream register file: commits on the edge after rfIsReading drops.
    always @(posedge clk) begin
        if (!bus.rfIsReading) rf[bus.rfSelWrite] <= bus.rfWriteIn;
    end

    typedef struct {
        logic        v0;
        logic [1:0]  a0;
        logic [63:0] d0;
        logic        v1;
        logic [1:0]  a1;
        logic [63:0] d1;
        logic        rd;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_isrd;
        logic [1:0]  e_sel;
        logic [63:0] e_wi;
        logic        e_gnt;
        logic [3:0]  e_pend;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " wrReady0"}, 64'(bus.wrReady0), 64'd1);
        check({tag, " wrReady1"}, 64'(bus.wrReady1), 64'd1);
        check({tag, " rfIsReading"}, 64'(bus.rfIsReading), 64'd1);
        check({tag, " rfSelWrite"}, 64'(bus.rfSelWrite), 64'd0);
        check({tag, " rfWriteIn"}, bus.rfWriteIn, Z);
        check({tag, " rdGrant"}, 64'(bus.rdGrant), 64'd0);
        check({tag, " pendingMask"}, 64'(bus.pendingMask), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk    = 1'b0;
        resetN = 1'b0;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 4; i++) rf[i] = Z;
        {bus.wrValid0, bus.wrValid1, bus.rdReq} = '0;
        {bus.wrAddr0, bus.wrAddr1, bus.wrData0, bus.wrData1} = '0;
        {bus_z.wrValid0, bus_z.wrValid1, bus_z.rdReq} = '0;
        {bus_z.wrAddr0, bus_z.wrAddr1, bus_z.wrData0, bus_z.wrData1} = '0;

        // v0 a0 d0 v1 a1 d1 rd | rdy0 rdy1 isrd sel wi gnt pend
        vecs[0]  = '{1, 1, A, 1, 2, B, 0, 0, 0, 1, 0, Z, 0, 4'b0110};
        vecs[1]  = '{0, 0, Z, 0, 0, Z, 0, 1, 0, 0, 1, A, 0, 4'b0110};
        vecs[2]  = '{0, 0, Z, 0, 0, Z, 0, 1, 1, 0, 2, B, 0, 4'b0100};
        vecs[3]  = '{0, 0, Z, 0, 0, Z, 0, 1, 1, 1, 2, B, 0, 4'b0000};
        vecs[4]  = '{1, 1, A, 0, 0, Z, 0, 0, 1, 1, 2, B, 0, 4'b0010};
        vecs[5]  = '{0, 0, Z, 0, 0, Z, 0, 1, 1, 0, 1, A, 0, 4'b0010};
        vecs[6]  = '{0, 0, Z, 0, 0, Z, 0, 1, 1, 1, 1, A, 0, 4'b0000};
        vecs[7]  = '{1, 3, C, 0, 0, Z, 1, 0, 1, 1, 1, A, 1, 4'b1000};
        vecs[8]  = '{0, 0, Z, 0, 0, Z, 1, 0, 1, 1, 1, A, 1, 4'b1000};
        vecs[9]  = '{0, 0, Z, 0, 0, Z, 1, 0, 1, 1, 1, A, 1, 4'b1000};
        vecs[10] = '{0, 0, Z, 0, 0, Z, 1, 0, 1, 1, 1, A, 1, 4'b1000};
        vecs[11] = '{0, 0, Z, 0, 0, Z, 1, 0, 1, 1, 1, A, 1, 4'b1000};
        vecs[12] = '{0, 0, Z, 0, 0, Z, 1, 1, 1, 0, 3, C, 0, 4'b1000};
        vecs[13] = '{0, 0, Z, 0, 0, Z, 1, 1, 1, 1, 3, C, 1, 4'b0000};
        vecs[14] = '{0, 0, Z, 0, 0, Z, 0, 1, 1, 1, 3, C, 0, 4'b0000};

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        resetN = 1'b1;

        // Dual accept, single accept and read-starvation sequences.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.wrValid0 = vecs[i].v0;
            bus.wrAddr0  = vecs[i].a0;
            bus.wrData0  = vecs[i].d0;
            bus.wrValid1 = vecs[i].v1;
            bus.wrAddr1  = vecs[i].a1;
            bus.wrData1  = vecs[i].d1;
            bus.rdReq    = vecs[i].rd;
            @(posedge clk);
            #1;
            check($sformatf("v%0d wrReady0", i), 64'(bus.wrReady0), 64'(vecs[i].e_rdy0));
            check($sformatf("v%0d wrReady1", i), 64'(bus.wrReady1), 64'(vecs[i].e_rdy1));
            check($sformatf("v%0d rfIsReading", i), 64'(bus.rfIsReading), 64'(vecs[i].e_isrd));
            check($sformatf("v%0d rfSelWrite", i), 64'(bus.rfSelWrite), 64'(vecs[i].e_sel));
            check($sformatf("v%0d rfWriteIn", i), bus.rfWriteIn, vecs[i].e_wi);
            check($sformatf("v%0d rdGrant", i), 64'(bus.rdGrant), 64'(vecs[i].e_gnt));
            check($sformatf("v%0d pendingMask", i), 64'(bus.pendingMask), 64'(vecs[i].e_pend));
        end
        check("rf r1", rf[1], A);
        check("rf r2", rf[2], B);
        check("rf r3", rf[3], C);

        // Reset pulsed mid-cycle while both slots are full and reads are stalling them.
        @(negedge clk);
        bus.wrValid0 = 1'b1; bus.wrAddr0 = 2'd1; bus.wrData0 = A;
        bus.wrValid1 = 1'b1; bus.wrAddr1 = 2'd2; bus.wrData1 = B;
        bus.rdReq    = 1'b1;
        @(negedge clk);
        bus.wrValid0 = 1'b0;
        bus.wrValid1 = 1'b0;
        check("pre-reset pendingMask", 64'(bus.pendingMask), 64'b0110);
        @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        check_reset_outputs("async reset");
        @(negedge clk);
        bus.rdReq = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-reset%0d rfIsReading", i), 64'(bus.rfIsReading), 64'd1);
            check($sformatf("post-reset%0d ready", i), 64'({bus.wrReady0, bus.wrReady1}), 64'b11);
        end

        // Both requesters streaming to distinct registers: issues alternate.
        @(negedge clk);
        bus.wrValid0 = 1'b1; bus.wrAddr0 = 2'd1; bus.wrData0 = A;
        bus.wrValid1 = 1'b1; bus.wrAddr1 = 2'd2; bus.wrData1 = B;
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("alt%0d rfIsReading", k), 64'(bus.rfIsReading), 64'd0);
            check($sformatf("alt%0d rfSelWrite", k), 64'(bus.rfSelWrite),
                  (k % 2 == 0) ? 64'd1 : 64'd2);
        end
        @(negedge clk);
        bus.wrValid0 = 1'b0;
        bus.wrValid1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("alt drain pendingMask", 64'(bus.pendingMask), 64'd0);

        // Write to R0 with the zero register read-only: accepted, then dropped.
        @(negedge clk);
        bus_z.wrValid1 = 1'b1;
        bus_z.wrAddr1  = 2'd0;
        bus_z.wrData1  = 64'h1;
        @(posedge clk);
        #1;
        check("r0 wrReady1", 64'(bus_z.wrReady1), 64'd1);
        check("r0 pendingMask", 64'(bus_z.pendingMask), 64'd0);
        @(negedge clk);
        bus_z.wrValid1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("r0 idle%0d rfIsReading", i), 64'(bus_z.rfIsReading), 64'd1);
            check($sformatf("r0 idle%0d pendingMask", i), 64'(bus_z.pendingMask), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
